// File: rtl/diff_add_mul_host_pkg.sv
// Shared definitions for the diff/add/mul host.
//   - bubble operand pattern driven to the engine when no real command is issued
//   - command, tag and result record types carried by the internal FIFOs
//   - golden reference: a = |i - j|, then (a + k) or (a * k), both mod 256
package diff_add_mul_host_pkg;

  localparam logic [7:0] BUBBLE_I  = 8'd0;
  localparam logic [7:0] BUBBLE_J  = 8'd0;
  localparam logic [7:0] BUBBLE_K  = 8'd0;
  localparam logic       BUBBLE_OP = 1'b1;

  typedef struct packed {
    logic [7:0] i;
    logic [7:0] j;
    logic [7:0] k;
    logic       op;
  } cmd_t;

  typedef struct packed {
    logic       bubble;
    logic [7:0] golden;
  } tag_t;

  typedef struct packed {
    logic [7:0] data;
    logic       mismatch;
  } res_t;

  function automatic logic [7:0] golden_calc(input logic [7:0] i,
                                             input logic [7:0] j,
                                             input logic [7:0] k,
                                             input logic       op);
    logic [7:0] a;
    logic [7:0] r;
    a = (i >= j) ? (i - j) : (j - i);
    if (op) r = a + k;
    else    r = a * k;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO.
//   clk, rst       : clock, synchronous active-high reset (empties the FIFO)
//   push/push_data : write request; accepted when not full, or when full and
//                    popping in the same cycle
//   pop/pop_data   : read request; pop_data is the current head, readable
//                    combinationally so the consumer can act on it in the
//                    same cycle it pops; pop on empty is ignored
//   full/empty/count : occupancy status, all registered-state derived
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CW'(DEPTH));
  assign count    = count_reg;
  assign pop_data = mem[rd_ptr_reg];

  // A push into a full FIFO is still legal when the head leaves this cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/diff_add_mul_host.sv
// Host wrapper around a pipelined diff/add/mul engine.
//   cmd_*        : command input (valid/ready), operands i/j/k and op (1=add)
//   dut_*        : operands presented to the engine; dut_in_valid marks an
//                  engine acceptance, dut_vo/dut_out_valid return results in
//                  acceptance order
//   res_*        : checked results (valid/ready), res_mismatch flags results
//                  that differ from the golden reference
//   err_timeout  : sticky, engine silent for WDOG_CYC cycles with work pending
//   err_overflow : sticky, tag FIFO overrun or result with no outstanding tag
//   issued_cnt / done_cnt : real commands issued / results retired (wrapping)
// Every acceptance pushes a tag; bubbles are issued when no command is ready
// or when the result FIFO could not absorb another real result.
module diff_add_mul_host
  import diff_add_mul_host_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int TAG_DEPTH = 8,
  parameter int RES_DEPTH = 4,
  parameter int WDOG_CYC  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_i,
  input  logic [7:0]  cmd_j,
  input  logic [7:0]  cmd_k,
  input  logic        cmd_op,
  output logic [7:0]  dut_i,
  output logic [7:0]  dut_j,
  output logic [7:0]  dut_k,
  output logic        dut_op,
  input  logic        dut_in_valid,
  input  logic [7:0]  dut_vo,
  input  logic        dut_out_valid,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_data,
  output logic        res_mismatch,
  output logic        err_timeout,
  output logic        err_overflow,
  output logic [15:0] issued_cnt,
  output logic [15:0] done_cnt
);

  localparam int CCW = $clog2(CMD_DEPTH + 1);
  localparam int TCW = $clog2(TAG_DEPTH + 1);
  localparam int RCW = $clog2(RES_DEPTH + 1);
  localparam int WW  = $clog2(WDOG_CYC + 1);

  // FIFO plumbing
  cmd_t           cmd_in;
  cmd_t           cmd_head;
  logic           cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic [CCW-1:0] cmd_count;

  tag_t           tag_in;
  tag_t           tag_head;
  logic           tag_push, tag_pop, tag_full, tag_empty;
  logic [TCW-1:0] tag_count;

  res_t           res_in;
  res_t           res_head;
  logic           res_push, res_pop, res_full, res_empty;
  logic [RCW-1:0] res_count;

  // control
  logic           credit_ok;
  logic           issue_real;
  logic           real_accept;
  logic           accept;
  logic           tag_drop;
  logic           orphan_out;
  logic           real_retire;
  logic           inflight_inc;

  logic [TCW-1:0] inflight_reg, inflight_next;
  logic [WW-1:0]  wdog_reg, wdog_next;
  logic [15:0]    issued_cnt_reg, done_cnt_reg;
  logic           err_timeout_reg, err_overflow_reg;

  logic           fifo_status_unused;
  assign fifo_status_unused = ^{cmd_count, tag_count, res_full};

  // ---------------------------------------------------------------- command
  assign cmd_ready = !rst && !cmd_full;
  assign cmd_push  = cmd_valid && cmd_ready;
  assign cmd_in    = '{i: cmd_i, j: cmd_j, k: cmd_k, op: cmd_op};

  sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_push),
    .push_data (cmd_in),
    .pop       (cmd_pop),
    .pop_data  (cmd_head),
    .full      (cmd_full),
    .empty     (cmd_empty),
    .count     (cmd_count)
  );

  // Credit counts results already queued plus real results still inside the
  // engine, both from registered state, so a result pop only frees a slot
  // from the following cycle on.
  assign credit_ok  = (32'(res_count) + 32'(inflight_reg)) < 32'(RES_DEPTH);
  assign issue_real = !rst && !cmd_empty && credit_ok;

  assign dut_i  = issue_real ? cmd_head.i  : BUBBLE_I;
  assign dut_j  = issue_real ? cmd_head.j  : BUBBLE_J;
  assign dut_k  = issue_real ? cmd_head.k  : BUBBLE_K;
  assign dut_op = issue_real ? cmd_head.op : BUBBLE_OP;

  assign accept      = dut_in_valid && !rst;
  assign real_accept = accept && issue_real;
  assign cmd_pop     = real_accept;

  // -------------------------------------------------------------------- tag
  assign tag_in.bubble = !issue_real;
  assign tag_in.golden = issue_real ? golden_calc(cmd_head.i, cmd_head.j,
                                                  cmd_head.k, cmd_head.op)
                                    : 8'd0;

  assign tag_pop    = dut_out_valid && !rst && !tag_empty;
  assign tag_push   = accept && (!tag_full || tag_pop);
  assign tag_drop   = accept && tag_full && !tag_pop;
  assign orphan_out = dut_out_valid && !rst && tag_empty;

  sync_fifo #(.WIDTH($bits(tag_t)), .DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tag_push),
    .push_data (tag_in),
    .pop       (tag_pop),
    .pop_data  (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  // ----------------------------------------------------------------- result
  assign real_retire = tag_pop && !tag_head.bubble;
  assign res_push    = real_retire;
  assign res_in      = '{data: dut_vo, mismatch: (dut_vo != tag_head.golden)};

  assign res_valid    = !rst && !res_empty;
  assign res_pop      = res_valid && res_ready;
  assign res_data     = res_valid ? res_head.data : 8'd0;
  assign res_mismatch = res_valid && res_head.mismatch;

  sync_fifo #(.WIDTH($bits(res_t)), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (res_push),
    .push_data (res_in),
    .pop       (res_pop),
    .pop_data  (res_head),
    .full      (res_full),
    .empty     (res_empty),
    .count     (res_count)
  );

  // A real command whose tag was dropped can never retire, so it holds no
  // credit.
  assign inflight_inc = real_accept && tag_push;

  always_comb begin
    inflight_next = inflight_reg;
    case ({inflight_inc, real_retire})
      2'b10:   inflight_next = inflight_reg + TCW'(1);
      2'b01:   inflight_next = inflight_reg - TCW'(1);
      default: inflight_next = inflight_reg;
    endcase
  end

  // Watchdog saturates at WDOG_CYC; the error latches on the edge it gets there.
  always_comb begin
    wdog_next = wdog_reg;
    if (dut_out_valid || tag_empty)
      wdog_next = '0;
    else if (wdog_reg != WW'(WDOG_CYC))
      wdog_next = wdog_reg + WW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_reg     <= '0;
      wdog_reg         <= '0;
      issued_cnt_reg   <= '0;
      done_cnt_reg     <= '0;
      err_timeout_reg  <= 1'b0;
      err_overflow_reg <= 1'b0;
    end else begin
      inflight_reg <= inflight_next;
      wdog_reg     <= wdog_next;
      if (real_accept) issued_cnt_reg <= issued_cnt_reg + 16'd1;
      if (real_retire) done_cnt_reg   <= done_cnt_reg + 16'd1;
      if (wdog_next == WW'(WDOG_CYC)) err_timeout_reg <= 1'b1;
      if (tag_drop || orphan_out)     err_overflow_reg <= 1'b1;
    end
  end

  assign issued_cnt   = issued_cnt_reg;
  assign done_cnt     = done_cnt_reg;
  assign err_timeout  = err_timeout_reg;
  assign err_overflow = err_overflow_reg;

endmodule

// File: doc/diff_add_mul_host.md
DIFF_ADD_MUL_HOST -- requirements
Module: diff_add_mul_host

Interface
REQ-001 SHALL have parameters: CMD_DEPTH, default 4, command FIFO entries; TAG_DEPTH, default 8, in-flight tag FIFO entries; RES_DEPTH, default 4, result FIFO entries; WDOG_CYC, default 64, timeout cycles.
REQ-002 SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-003 SHALL have ports, as name, direction, width, meaning:
- clk  in  1  clock
- rst  in  1  sync active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command FIFO not full
- cmd_i, cmd_j, cmd_k  in  8 each  operands
- cmd_op  in  1  1=add, 0=multiply
- dut_i, dut_j, dut_k  out  8 each  operands to engine
- dut_op  out  1  operation to engine
- dut_in_valid  in  1  engine accepts operands this cycle
- dut_vo  in  8  engine result
- dut_out_valid  in  1  engine result valid
- res_valid  out  1  result FIFO not empty
- res_ready  in  1  consumer pops
- res_data  out  8  engine result
- res_mismatch  out  1  res_data differs from golden
- err_timeout, err_overflow  out  1 each  sticky errors
- issued_cnt, done_cnt  out  16 each  real commands issued / results retired

Function
REQ-004 SHALL push a command when cmd_valid and cmd_ready are both high; cmd_ready SHALL be high iff the command FIFO is not full.
REQ-005 SHALL treat every cycle with dut_in_valid=1 as one engine acceptance of dut_i/j/k/op at that clk edge. Each acceptance yields exactly one dut_out_valid pulse, and pulses arrive in acceptance order.
REQ-006 SHALL issue a real command on an acceptance only if both conditions hold:
- the command FIFO is non-empty;
- (RES_DEPTH - result occupancy - real in-flight) > 0.
REQ-007 SHALL otherwise issue a bubble (dut_i=0, dut_j=0, dut_k=0, dut_op=1) and SHALL drive the bubble pattern whenever no real command is presented.
REQ-008 SHALL pop the command FIFO on the same edge a real command is accepted, and SHALL drive the FIFO head combinationally onto dut_* when issuing.
REQ-009 SHALL push a tag {bubble, golden[7:0]} into the tag FIFO per acceptance.
REQ-010 SHALL compute golden for real commands as follows:
- a = |i - j| (8-bit);
- golden = op ? (a + k) mod 256 : (a * k) mod 256.
REQ-011 SHALL pop the tag FIFO on each dut_out_valid:
- bubble tags: dut_vo is discarded;
- real tags: push {dut_vo, dut_vo != golden} into the result FIFO and increment done_cnt.
REQ-012 SHALL increment issued_cnt per real acceptance; both counters wrap at 16 bits.
REQ-013 SHALL set err_overflow on a tag push while the tag FIFO is full (the push is dropped), or on dut_out_valid while the tag FIFO is empty (the result is dropped).
REQ-014 SHALL run a watchdog counter that clears on dut_out_valid or when the tag FIFO is empty, and otherwise increments. err_timeout SHALL set when the counter reaches WDOG_CYC.
REQ-015 SHALL handle simultaneous push/pop on any FIFO in one cycle with occupancy unchanged. A pop on full and a push on empty SHALL be legal.
REQ-016 SHALL count a result-FIFO pop (res_valid && res_ready) in the same cycle as a result push when freeing credit for the next cycle only, not combinationally.

Reset
REQ-017 SHALL, while rst is high, empty all FIFOs and clear both counters, both error flags and the watchdog.
REQ-018 SHALL hold these values during reset: cmd_ready=0, res_valid=0, res_mismatch=0, dut_* = bubble pattern.
REQ-019 SHALL discard any in-flight tags when rst asserts mid-operation, and SHALL resume with cmd_ready=1 on the first cycle after reset deasserts.

Structure
REQ-020 SHALL place the following in the shared DiffAddMul package:
- bubble constants;
- the tag record type {bubble, golden};
- the golden-model function (|i-j| then add/mul mod 256).
REQ-021 SHALL instantiate one generic sub-module, sync_fifo (WIDTH, DEPTH; full/empty/count), three times (command, tag, result).

Verification
REQ-022 SHALL cover these directed scenarios:
- Add: i=10, j=3, k=5, op=1 -> res_data=12, res_mismatch=0, done_cnt=1.
- Negative diff, multiply: i=3, j=10, k=40, op=0 -> res_data=0x18 (280 mod 256), res_mismatch=0.
- Empty command FIFO with dut_in_valid high for 5 cycles -> 5 bubbles issued, no res_valid, issued_cnt=0.
- res_ready=0 with 6 commands queued -> at most 4 results held, no result lost, cmd_ready drops after 4 commands are queued, and all 6 drain in order once res_ready=1.
- Tag FIFO non-empty and dut_out_valid held 0 for 64 cycles -> err_timeout=1 and sticky until rst.
- rst pulsed with 2 real commands in flight -> counters 0, FIFOs empty; late dut_out_valid pulses -> err_overflow=1, no res_valid.
